// File: rtl/swap_issuer.sv
// swap_issuer: command front end for the swapping register file.
// Requests enter a small FIFO through a valid/ready handshake. Illegal or
// no-op requests are dropped with an err pulse. Each legal request is issued
// to the register file as a one-cycle swap pulse. Its addresses are held
// steady for the whole swap sequence.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready depends only on FIFO fullness, never on a same-cycle pop. While
// req_ready is low, the requester must hold req_valid and the request data.
module swap_issuer #(
   parameter int DEPTH       = 4,
   parameter int SWAP_CYCLES = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [4:0]             req_a,
   input  logic [4:0]             req_b,
   output logic                   swap,
   output logic [4:0]             addr_a,
   output logic [4:0]             addr_b,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(SWAP_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [9:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          push;
   logic          pop;
   logic          empty;
   logic          full;
   logic          head_bad;
   logic [4:0]    head_a;
   logic [4:0]    head_b;

   assign full      = (level == (AW+1)'(DEPTH));
   assign empty     = (level == '0);
   assign req_ready = !full;
   assign push      = req_valid && !full;
   // The head is popped in any IDLE cycle; a same-cycle push is not visible yet.
   assign pop       = (state == IDLE) && !empty;
   assign head_a    = mem[rd_ptr][9:5];
   assign head_b    = mem[rd_ptr][4:0];
   // Register 0 is the register file's swap temporary, so it is never a legal operand.
   assign head_bad  = (head_a == head_b) || (head_a == 5'd0) || (head_b == 5'd0);

   // FIFO storage; contents need no reset because the pointers and level define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {req_a, req_b};
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Datapath registers: latched addresses, swap countdown and the discard pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_a <= '0;
         addr_b <= '0;
         cnt    <= '0;
         err    <= 1'b0;
      end else begin
         err <= pop && head_bad;
         if (pop && !head_bad) begin
            addr_a <= head_a;
            addr_b <= head_b;
         end
         if (state == ISSUE) begin
            cnt <= CW'(SWAP_CYCLES - 1);
         end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
         end
      end
   end

   // Next-state logic: illegal heads keep the FSM in IDLE so they drain one per cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pop && !head_bad) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (cnt == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Moore outputs decoded from the registered state.
   always_comb begin
      swap = (state == ISSUE);
      busy = (state != IDLE);
      done = (state == WAIT) && (cnt == '0);
   end

endmodule

// File: tb/tb_swap_issuer.sv
// tb_swap_issuer: randomized and directed stimulus for swap_issuer.
// The reference model schedules events as cycle timestamps. It tracks when
// the issuer is next free, when a swap, done or err is due, and a queue of
// the requests it has accepted.
module tb_swap_issuer;

   localparam int DEPTH = 4;
   localparam int SC    = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic [4:0] req_a = '0;
   logic [4:0] req_b = '0;
   logic       req_ready;
   logic       swap;
   logic [4:0] addr_a;
   logic [4:0] addr_b;
   logic       busy;
   logic       done;
   logic       err;
   logic [$clog2(DEPTH):0] level;

   swap_issuer #(.DEPTH(DEPTH), .SWAP_CYCLES(SC)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .swap      (swap),
      .addr_a    (addr_a),
      .addr_b    (addr_b),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .level     (level)
   );

   // clock
   always #5 clk = ~clk;

   // scoreboard / model state
   int         n_vec = 0;
   int         n_err = 0;
   int         cyc = 0;
   logic [9:0] pend[$];
   logic [9:0] exp_q[$];
   int         free_at = 0;
   int         swap_at = -1;
   int         done_at = -1;
   int         err_at = -1;
   logic [4:0] ea = '0;
   logic [4:0] eb = '0;
   int         valid_pct = 100;
   bit         holding = 1'b0;
   int         want_lvl = -1;
   int         n_swap = 0;
   int         n_done = 0;
   int         n_errp = 0;
   int         n_full = 0;
   int         sw_q[$];
   int         acc_q[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
      end
   endtask

   task automatic check_outputs();
      bit e_busy;
      e_busy = (swap_at >= 0) && (cyc >= swap_at) && (cyc <= done_at);
      check_val("req_ready", req_ready, exp_q.size() < DEPTH);
      check_val("level", level, exp_q.size());
      check_val("swap", swap, cyc == swap_at);
      check_val("busy", busy, e_busy);
      check_val("done", done, cyc == done_at);
      check_val("err", err, cyc == err_at);
      check_val("addr_a", addr_a, ea);
      check_val("addr_b", addr_b, eb);
      if (want_lvl >= 0) begin
         check_val("pp_level", level, want_lvl);
         want_lvl = -1;
      end
      if (swap === 1'b1) begin
         n_swap++;
         sw_q.push_back(cyc);
      end
      if (done === 1'b1) n_done++;
      if (err === 1'b1) n_errp++;
      if (req_ready === 1'b0) n_full++;
   endtask

   // one clock cycle: check, drive, advance model across the closing edge
   task automatic step(input bit do_rst);
      logic [9:0] e;
      bit         rdy;
      @(negedge clk);
      check_outputs();
      rst = do_rst;
      if (do_rst) begin
         req_valid = 1'b0;
         holding   = 1'b0;
      end else if (holding) begin
         req_valid = 1'b1;
      end else if (pend.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
         e         = pend[0];
         req_valid = 1'b1;
         req_a     = e[9:5];
         req_b     = e[4:0];
      end else begin
         req_valid = 1'b0;
      end
      rdy = exp_q.size() < DEPTH;
      if (do_rst) begin
         exp_q.delete();
         free_at = cyc + 1;
         swap_at = -1;
         done_at = -1;
         err_at  = -1;
         ea      = '0;
         eb      = '0;
      end else begin
         if (cyc >= free_at && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e[9:5] == e[4:0] || e[9:5] == 5'd0 || e[4:0] == 5'd0) begin
               err_at  = cyc + 1;
               free_at = cyc + 1;
            end else begin
               ea      = e[9:5];
               eb      = e[4:0];
               swap_at = cyc + 1;
               done_at = cyc + 1 + SC;
               free_at = cyc + 2 + SC;
            end
         end
         if (req_valid && rdy) begin
            exp_q.push_back({req_a, req_b});
            void'(pend.pop_front());
            acc_q.push_back(cyc);
            holding = 1'b0;
         end else begin
            holding = req_valid;
         end
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && (pend.size() > 0 || exp_q.size() > 0 || cyc <= free_at || holding); i++) begin
         step(1'b0);
      end
      if (pend.size() > 0 || exp_q.size() > 0 || holding) check_val("drain_timeout", 1, 0);
   endtask

   task automatic clr();
      n_swap = 0;
      n_done = 0;
      n_errp = 0;
      n_full = 0;
      sw_q.delete();
      acc_q.delete();
      valid_pct = 100;
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);

      // single swap (3,7): swap two cycles after acceptance
      clr();
      pend.push_back({5'd3, 5'd7});
      repeat (8) step(1'b0);
      check_val("s1_lat", (sw_q.size() > 0 && acc_q.size() > 0) ? sw_q[0] - acc_q[0] : -1, 2);
      check_val("s1_done", n_done, 1);

      // illegal requests drain with err, the legal one swaps
      drain();
      clr();
      pend.push_back({5'd5, 5'd5});
      pend.push_back({5'd0, 5'd9});
      pend.push_back({5'd4, 5'd2});
      repeat (12) step(1'b0);
      check_val("s2_err", n_errp, 2);
      check_val("s2_swap", n_swap, 1);
      check_val("s2_done", n_done, 1);

      // full FIFO while a swap is active
      drain();
      clr();
      pend.push_back({5'd1, 5'd2});
      repeat (2) step(1'b0);
      for (int i = 0; i < 5; i++) pend.push_back({5'(6 + 2 * i), 5'(7 + 2 * i)});
      repeat (45) step(1'b0);
      drain();
      check_val("s3_done", n_done, 6);
      check_val("s3_full_seen", n_full > 0, 1);

      // back-to-back spacing
      drain();
      clr();
      pend.push_back({5'd1, 5'd2});
      pend.push_back({5'd3, 5'd4});
      repeat (15) step(1'b0);
      check_val("s4_gap", (sw_q.size() > 1) ? sw_q[1] - sw_q[0] : -1, SC + 2);

      // reset during the second WAIT cycle with two entries queued
      drain();
      clr();
      pend.push_back({5'd1, 5'd2});
      pend.push_back({5'd3, 5'd4});
      pend.push_back({5'd5, 5'd6});
      repeat (4) step(1'b0);
      step(1'b1);
      repeat (10) step(1'b0);
      check_val("s5_done", n_done, 0);
      check_val("s5_swap", n_swap, 1);

      // simultaneous push and pop at level 2
      drain();
      clr();
      pend.push_back({5'd1, 5'd2});
      pend.push_back({5'd3, 5'd4});
      pend.push_back({5'd5, 5'd6});
      repeat (3) step(1'b0);
      valid_pct = 0;
      pend.push_back({5'd7, 5'd8});
      repeat (3) step(1'b0);
      valid_pct = 100;
      step(1'b0);
      want_lvl = 2;
      step(1'b0);
      drain();

      // random traffic with occasional resets
      clr();
      for (int i = 0; i < 800; i++) begin
         valid_pct = $urandom_range(20, 100);
         if (pend.size() < 4 && $urandom_range(0, 3) != 0) begin
            pend.push_back({5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))});
         end
         step($urandom_range(0, 249) == 0);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
